// File: rtl/vcu118_infra_pkg.sv
// Shared definitions for the VCU118 reset sequencer: state encodings,
// state width and the lock-loss counter helper.
package vcu118_infra_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_IDLY = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == {LOSS_CNT_W{1'b1}}) ? v : v + LOSS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/vcu118_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vcu118_reset_sequencer.sv
// Staged reset sequencer for the VCU118 clock infrastructure. Filters MMCM
// lock, waits for IDELAYCTRL ready, then releases stage resets in order
// (bit 0 first), tracking IDELAY timeouts and lock-loss events.
module vcu118_reset_sequencer
    import vcu118_infra_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int STAGE_DELAY    = 256,
    parameter int LOCK_FILTER    = 16,
    parameter int IDELAY_TIMEOUT = 65535
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  pll_lock,
    input  logic                  idelay_rdy,
    input  logic                  soft_rst_req,
    output logic [STAGES-1:0]     stage_rst,
    output logic                  infra_ready,
    output logic                  idelay_fault,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [STATE_W-1:0]    seq_state
);

    localparam int FILT_W = $clog2(LOCK_FILTER) + 1;
    localparam int TMO_W  = $clog2(IDELAY_TIMEOUT) + 1;
    localparam int DLY_W  = $clog2(STAGE_DELAY) + 1;

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(IDELAY_TIMEOUT - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);

    logic lock_s;
    logic idly_s;

    seq_state_e            state_q, state_d;
    logic [STAGES-1:0]     stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  fault_q, fault_d;
    logic [LOSS_CNT_W-1:0] cnt_q, cnt_d;
    logic [FILT_W-1:0]     filt_q, filt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [DLY_W-1:0]      dly_q, dly_d;

    sync_2ff u_sync_lock (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    sync_2ff u_sync_idly (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (idelay_rdy),
        .q_o   (idly_s)
    );

    // State, outputs and counters; everything returns to its reset value asynchronously.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_HOLD;
            stage_q <= '1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            filt_q  <= '0;
            tmo_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            tmo_q   <= tmo_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic; lock loss and soft reset override the per-state decision.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        tmo_d   = tmo_q;
        dly_d   = dly_q;

        case (state_q)
            ST_HOLD: begin
                stage_d = '1;
                if (!lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FILT_LAST) begin
                    filt_d  = '0;
                    tmo_d   = '0;
                    state_d = ST_WAIT_IDLY;
                end else begin
                    filt_d = filt_q + FILT_W'(1);
                end
            end
            ST_WAIT_IDLY: begin
                if (idly_s) begin
                    // Stage 0 drops on the same edge that enters RELEASE.
                    state_d = ST_RELEASE;
                    stage_d = stage_q << 1;
                    dly_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RELEASE: begin
                if (stage_q == '0) begin
                    state_d = ST_RUN;
                end else if (dly_q == DLY_LAST) begin
                    stage_d = stage_q << 1;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_RUN: begin
                stage_d = '0;
            end
            ST_FAULT: begin
                stage_d = '1;
            end
            default: begin
                state_d = ST_HOLD;
                stage_d = '1;
            end
        endcase

        if (state_q != ST_HOLD) begin
            if (!lock_s) begin
                state_d = ST_HOLD;
                stage_d = '1;
                filt_d  = '0;
                cnt_d   = sat_inc(cnt_q);
            end else if (soft_rst_req) begin
                state_d = ST_HOLD;
                stage_d = '1;
                filt_d  = '0;
            end
        end

        ready_d = (state_d == ST_RUN);
    end

    assign stage_rst     = stage_q;
    assign infra_ready   = ready_q;
    assign idelay_fault  = fault_q;
    assign lock_loss_cnt = cnt_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_vcu118_reset_sequencer.sv
// Scoreboard bench for vcu118_reset_sequencer with short delays/filters.
module tb_vcu118_reset_sequencer;

    localparam int STAGES = 3;
    localparam int SD     = 8;
    localparam int LF     = 4;
    localparam int TO     = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pll_lock;
    logic        idelay_rdy;
    logic        soft_rst_req;
    logic [2:0]  stage_rst;
    logic        infra_ready;
    logic        idelay_fault;
    logic [7:0]  lock_loss_cnt;
    logic [2:0]  seq_state;

    vcu118_reset_sequencer #(
        .STAGES         (STAGES),
        .STAGE_DELAY    (SD),
        .LOCK_FILTER    (LF),
        .IDELAY_TIMEOUT (TO)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .pll_lock      (pll_lock),
        .idelay_rdy    (idelay_rdy),
        .soft_rst_req  (soft_rst_req),
        .stage_rst     (stage_rst),
        .infra_ready   (infra_ready),
        .idelay_fault  (idelay_fault),
        .lock_loss_cnt (lock_loss_cnt),
        .seq_state     (seq_state)
    );

    always #5 sys_clk = ~sys_clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int    at;
        string tag;
        int    stg;
        int    rdy;
        int    flt;
        int    cnt;
        int    st;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, required %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input int stg, input int rdy,
                             input int flt, input int cnt, input int st);
        exp_t e;
        e.at = at; e.tag = tag; e.stg = stg; e.rdy = rdy;
        e.flt = flt; e.cnt = cnt; e.st = st;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag, input int stg, input int rdy,
                             input int flt, input int cnt, input int st);
        chk({tag, "_stage"}, 32'(stage_rst), stg);
        chk({tag, "_ready"}, 32'(infra_ready), rdy);
        chk({tag, "_fault"}, 32'(idelay_fault), flt);
        chk({tag, "_cnt"},   32'(lock_loss_cnt), cnt);
        chk({tag, "_state"}, 32'(seq_state), st);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Compare the DUT on the falling edge against entries scheduled for this cycle.
    always @(negedge sys_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) chk({e.tag, "_missed"}, cyc, e.at);
            else check_now(e.tag, e.stg, e.rdy, e.flt, e.cnt, e.st);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t, b, e2, t2, d, f, t3, c;

        sys_rst = 1'b1; pll_lock = 1'b1; idelay_rdy = 1'b1; soft_rst_req = 1'b0;
        tick(3);
        check_now("reset", 7, 0, 0, 0, 0);

        // Clean bring-up: T = release edge + 2 sync + LF filter edges.
        sys_rst = 1'b0; e = cyc; t = e + 2 + LF;
        expect_at(t - 1,  "s1_hold",     7, 0, 0, 0, 0);
        expect_at(t,      "s1_wait",     7, 0, 0, 0, 1);
        expect_at(t + 1,  "s1_rel0",     6, 0, 0, 0, 2);
        expect_at(t + 8,  "s1_rel0_end", 6, 0, 0, 0, 2);
        expect_at(t + 9,  "s1_rel1",     4, 0, 0, 0, 2);
        expect_at(t + 16, "s1_rel1_end", 4, 0, 0, 0, 2);
        expect_at(t + 17, "s1_rel2",     0, 0, 0, 0, 2);
        expect_at(t + 18, "s1_run",      0, 1, 0, 0, 3);
        wait_until(t + 20);

        // Lock glitch in HOLD: 3 high, 1 low, then high again.
        pll_lock = 1'b0; sys_rst = 1'b1; #1;
        check_now("s2_rst", 7, 0, 0, 0, 0);
        tick(2); sys_rst = 1'b0; tick(3);
        b = cyc; pll_lock = 1'b1;
        expect_at(b + 6,  "s2_glitch_hold", 7, 0, 0, 0, 0);
        expect_at(b + 9,  "s2_hold",        7, 0, 0, 0, 0);
        expect_at(b + 10, "s2_wait",        7, 0, 0, 0, 1);
        expect_at(b + 11, "s2_rel0",        6, 0, 0, 0, 2);
        expect_at(b + 28, "s2_run",         0, 1, 0, 0, 3);
        tick(3); pll_lock = 1'b0;
        tick(1); pll_lock = 1'b1;
        wait_until(b + 30);

        // IDELAY timeout, then soft reset recovery with the fault kept.
        sys_rst = 1'b1; idelay_rdy = 1'b0; pll_lock = 1'b1;
        tick(2); sys_rst = 1'b0; e = cyc; t = e + 2 + LF;
        expect_at(t,      "s3_wait",       7, 0, 0, 0, 1);
        expect_at(t + 19, "s3_wait_end",   7, 0, 0, 0, 1);
        expect_at(t + 20, "s3_fault",      7, 0, 1, 0, 4);
        expect_at(t + 22, "s3_fault_hold", 7, 0, 1, 0, 4);
        wait_until(t + 23);
        e2 = cyc; t2 = e2 + 1 + LF;
        expect_at(e2 + 1,  "s3_soft_hold", 7, 0, 1, 0, 0);
        expect_at(t2 - 1,  "s3_hold",      7, 0, 1, 0, 0);
        expect_at(t2,      "s3_wait2",     7, 0, 1, 0, 1);
        expect_at(t2 + 1,  "s3_rel0",      6, 0, 1, 0, 2);
        expect_at(t2 + 18, "s3_run",       0, 1, 1, 0, 3);
        soft_rst_req = 1'b1; idelay_rdy = 1'b1;
        tick(1); soft_rst_req = 1'b0;
        wait_until(t2 + 20);

        // Repeated lock loss from RUN; counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            d = cyc; pll_lock = 1'b0;
            c = (i + 1 < 255) ? i + 1 : 255;
            expect_at(d + 2,  $sformatf("s4_pre_%0d", i),  0, 1, 1, (i < 255) ? i : 255, 3);
            expect_at(d + 3,  $sformatf("s4_loss_%0d", i), 7, 0, 1, c, 0);
            expect_at(d + 27, $sformatf("s4_run_%0d", i),  0, 1, 1, c, 3);
            tick(3); pll_lock = 1'b1;
            wait_until(d + 28);
        end

        // Simultaneous lock loss and soft reset in RELEASE.
        sys_rst = 1'b1; pll_lock = 1'b1; idelay_rdy = 1'b1; #1;
        check_now("s5_rst", 7, 0, 0, 0, 0);
        tick(2); sys_rst = 1'b0; e = cyc; t = e + 2 + LF;
        expect_at(t + 1, "s5_rel0",  6, 0, 0, 0, 2);
        expect_at(t + 6, "s5_pre",   6, 0, 0, 0, 2);
        expect_at(t + 7, "s5_both",  7, 0, 0, 1, 0);
        expect_at(t + 8, "s5_after", 7, 0, 0, 1, 0);
        wait_until(t + 4); pll_lock = 1'b0;
        wait_until(t + 6); soft_rst_req = 1'b1;
        tick(1); soft_rst_req = 1'b0; pll_lock = 1'b1;

        // Asynchronous sys_rst mid-RELEASE.
        f = cyc; t3 = f + 2 + LF;
        expect_at(t3 + 1, "s6_rel0", 6, 0, 0, 1, 2);
        expect_at(t3 + 9, "s6_rel1", 4, 0, 0, 1, 2);
        wait_until(t3 + 10);
        sys_rst = 1'b1; #1;
        check_now("s6_async_rst", 7, 0, 0, 0, 0);
        tick(2);

        if (sb.size() != 0) chk("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vcu118_reset_sequencer.md
# vcu118_reset_sequencer

Consumes the clock/reset status produced by the VCU118 clock infrastructure: MMCM lock, the infrastructure reset, and IDELAYCTRL ready. It turns them into an ordered set of staged resets for downstream logic (DSP, application, fabric interfaces) and reports lock-loss and IDELAY faults. It runs on `sys_clk` and sits between the infrastructure block and every yellow-block reset consumer.

## Interface
Parameters:
- `STAGES`, 3: number of staged reset outputs; bit 0 is released first.
- `STAGE_DELAY`, 256: cycles between consecutive stage releases (≥1).
- `LOCK_FILTER`, 16: consecutive cycles synchronized lock must be high before sequencing starts (≥1).
- `IDELAY_TIMEOUT`, 65535: cycles to wait for IDELAY ready before declaring a fault (≥1).

Ports:
- `sys_clk`  in  1  sole clock.
- `sys_rst`  in  1  reset; asynchronous, active-high.
- `pll_lock`  in  1  MMCM lock; asynchronous, synchronized internally.
- `idelay_rdy`  in  1  IDELAYCTRL ready; asynchronous, synchronized internally.
- `soft_rst_req`  in  1  single-cycle request to re-run the sequence; synchronous.
- `stage_rst`  out  STAGES  active-high staged resets.
- `infra_ready`  out  1  high only in RUN.
- `idelay_fault`  out  1  sticky; set on IDELAY timeout.
- `lock_loss_cnt`  out  8  saturating count of lock-loss events.
- `seq_state`  out  3  current state encoding, for debug.

## Operation
- Both async inputs pass through a 2-flop synchronizer: `lock_s` and `idly_s`, 2 cycles of latency.
- States (encoding): HOLD=0, WAIT_IDLY=1, RELEASE=2, RUN=3, FAULT=4.
- HOLD: all `stage_rst`=1. The filter counter increments while `lock_s`=1 and clears when `lock_s`=0. When it reaches LOCK_FILTER, go to WAIT_IDLY.
- WAIT_IDLY: the timeout counter starts at 0.
  - On `idly_s`=1, go to RELEASE and deassert `stage_rst[0]` on the same edge.
  - When the counter reaches IDELAY_TIMEOUT with `idly_s`=0, go to FAULT and set `idelay_fault`.
- RELEASE: `stage_rst[k]` deasserts STAGE_DELAY cycles after `stage_rst[k-1]`. One cycle after the last stage deasserts, go to RUN.
- RUN: `infra_ready`=1 and all `stage_rst`=0.
- FAULT: all `stage_rst`=1 and `infra_ready`=0. Leave only via `soft_rst_req` (to HOLD), lock loss (to HOLD), or `sys_rst`.
- Lock loss: `lock_s`=0 in any state other than HOLD.
  - Next state is HOLD.
  - `lock_loss_cnt` increments, saturating at 255.
  - All `stage_rst` reassert on the next edge.
- `soft_rst_req` in WAIT_IDLY, RELEASE, RUN, or FAULT goes to HOLD without counting a lock loss. In HOLD it is ignored.
- Simultaneous lock loss and `soft_rst_req`: lock loss wins and is counted once.
- `idelay_fault` clears only on `sys_rst`. It stays set through later successful sequences.
- `idly_s` dropping after WAIT_IDLY is ignored.

## Timing
- Reset values: state=HOLD, `stage_rst`=all 1, `infra_ready`=0, `idelay_fault`=0, `lock_loss_cnt`=0, `seq_state`=0, counters=0, synchronizer flops=0.
- All outputs are registered and there are no combinational input-to-output paths.
- Let edge T be the edge that enters WAIT_IDLY.
  - With `idly_s` already 1, the state is RELEASE and `stage_rst[0]`=0 after edge T+1.
  - `stage_rst[k]`=0 after edge T+1+k·STAGE_DELAY.
  - `infra_ready`=1 after edge T+2+(STAGES-1)·STAGE_DELAY.
- From `pll_lock` rising (with `sys_rst` low and settled), edge T is 2+LOCK_FILTER edges later.
- `pll_lock` falling causes `stage_rst` to reassert 3 edges later (2 synchronizer edges plus 1 state edge).
- `sys_rst` mid-sequence forces all outputs to their reset values asynchronously.

## Structure
- The shared package/header `vcu118_infra_pkg` holds the state encodings and the 3-bit state width.
- Sub-module `sync_2ff` (single-bit two-flop synchronizer with async reset) is instantiated twice.
- The remaining logic is one FSM with the filter, timeout, and stage-delay counters. Counter widths are `$clog2` of the respective parameter plus 1.

## Test plan
All scenarios use STAGES=3, STAGE_DELAY=8, LOCK_FILTER=4, IDELAY_TIMEOUT=20.
- Clean bring-up: release `sys_rst`, with `pll_lock`=1 and `idelay_rdy`=1 throughout.
  - `stage_rst` steps 111→110→100→000 at 8-cycle spacing.
  - `infra_ready`=1 one cycle after the final step.
  - `lock_loss_cnt`=0.
- Lock glitch in HOLD: `pll_lock` low for 1 cycle after 3 high cycles. The filter restarts and sequencing begins 4 clean synced cycles later.
- IDELAY timeout: hold `idelay_rdy`=0.
  - FAULT is entered 20 cycles after WAIT_IDLY, with `idelay_fault`=1 and `stage_rst`=111.
  - `soft_rst_req` then returns to HOLD, and with `idelay_rdy`=1 the sequence completes with `idelay_fault` still 1.
- Lock loss in RUN, repeated 300 times: `stage_rst`=111 three edges after each drop, and `lock_loss_cnt` saturates at 255.
- Simultaneous lock loss and `soft_rst_req` in RELEASE: the FSM goes to HOLD and `lock_loss_cnt` increments by exactly 1.
- `sys_rst` asserted mid-RELEASE: all outputs return to their reset values immediately (asynchronously), and `lock_loss_cnt`=0.
